regfile_dbg_port: RTL
=====================

// Module: regfile_dbg_port
// PURPOSE
//  Debug master on the register-file port; drives ra/we/wa/wd, the opposite side of regfile.
//  DUMP mode reads X0..X31 one by one and streams them out over valid/ready.
//  LOAD mode accepts a valid/ready stream and writes X0..X30 in order.
//  Sits beside the datapath; an external mux gives the regfile ports to this block while busy=1.
// PARAMETERS
//  N        64  register data width
//  NREGS    32  registers in the file; index width is 5
//  XZR_IDX  31  zero register; never written, reads as 0
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   synchronous, active-high
//  start      in   1   1-cycle request; sampled only in IDLE
//  mode       in   1   0=DUMP, 1=LOAD; sampled together with start
//  busy       out  1   1 in every state except IDLE
//  done       out  1   1-cycle pulse when an operation completes
//  rf_ra      out  5   regfile read address (to ra1)
//  rf_rd      in   N   regfile read data (from rd1, combinational)
//  rf_we      out  1   regfile write enable (to we3)
//  rf_wa      out  5   regfile write address (to wa3)
//  rf_wd      out  N   regfile write data (to wd3)
//  out_data   out  N   dumped register value
//  out_idx    out  5   index of out_data
//  out_valid  out  1   dump beat valid
//  out_ready  in   1   sink accepts the dump beat
//  in_data    in   N   value to load
//  in_valid   in   1   load beat valid
//  in_ready   out  1   block accepts the load beat
// BEHAVIOUR
//  - Reset: state=IDLE, idx=0, busy=0, done=0, out_valid=0, out_data=0, out_idx=0,
//    rf_ra=0, rf_we=0, rf_wa=0, rf_wd=0, in_ready=0.
//  - Reset is synchronous. Asserted mid-operation, it aborts the operation:
//    outputs take reset values at the next edge and a partial load is not undone.
//  - FSM states: IDLE, D_RD, D_OUT, LOAD, DONE.
//  - IDLE: on start & !mode go to D_RD; on start & mode go to LOAD; idx <= 0.
//  - D_RD: drive rf_ra=idx. At the edge, out_data <= rf_rd, out_idx <= idx, out_valid <= 1.
//    Then go to D_OUT.
//  - D_OUT: hold out_data, out_idx and out_valid until out_valid & out_ready.
//    - On that handshake: out_valid <= 0.
//    - If idx==31, go to DONE; otherwise idx <= idx+1 and go to D_RD.
//  - DUMP timing: first out_valid appears 2 edges after start is sampled.
//    Each beat takes at least 2 cycles, so a full dump takes at least 64 cycles.
//  - LOAD: in_ready=1 combinationally while in LOAD.
//    - rf_we = in_valid & in_ready, with rf_wa=idx and rf_wd=in_data, all combinational.
//    - The regfile commits the write at the same edge as the handshake.
//    - On handshake: if idx==30, go to DONE; otherwise idx <= idx+1.
//    - idx never reaches 31 in LOAD, so rf_we=1 with rf_wa=31 is illegal (assert).
//  - DONE: done=1 for exactly one cycle, then IDLE. busy=1 in DONE.
//  - start while busy: ignored, with no side effects.
//  - rf_we=0 in every state except LOAD. rf_ra=idx in D_RD and D_OUT, 0 elsewhere.
//  - out_valid never drops without a handshake, except on reset.
//  - in_valid outside LOAD: ignored; in_ready=0.
// TESTING
//  1. Regfile at init (Xi=i). Reset, DUMP, out_ready=1 -> 32 beats, idx 0..31,
//     data 0..30 then 0 for X31; done once; busy low 1 cycle after done.
//  2. DUMP, out_ready=0 for 5 cycles at beat idx=3 -> out_data=3 and out_valid held,
//     rf_ra stays 3, then resumes at idx 4.
//  3. LOAD in_data=100+i, then DUMP -> X0..X30 = 100..130, X31=0;
//     exactly 31 rf_we pulses; never wa=31.
//  4. LOAD with in_valid toggling 1,0,0,1 -> rf_we only on valid cycles,
//     idx increments only on handshakes.
//  5. start asserted in D_OUT and in LOAD -> no restart; beat sequence and idx unchanged.
//  6. reset at DUMP beat idx=10 -> next cycle busy=0, out_valid=0;
//     a new DUMP restarts at idx 0 with data 0.

Source files
------------

// File: rtl/regfile_dbg_port.sv
// ============================================================================
// Module      : regfile_dbg_port
// Description : Debug master for the register-file port. DUMP streams X0..X31
//               out over valid/ready. LOAD writes X0..X30 from a valid/ready
//               stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_dbg_port #(
    parameter int N       = 64,
    parameter int NREGS   = 32,
    parameter int XZR_IDX = 31
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         mode,
    output logic         busy,
    output logic         done,
    output logic [4:0]   rf_ra,
    input  logic [N-1:0] rf_rd,
    output logic         rf_we,
    output logic [4:0]   rf_wa,
    output logic [N-1:0] rf_wd,
    output logic [N-1:0] out_data,
    output logic [4:0]   out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready
);

    localparam logic [4:0] c_last_dump = 5'(NREGS - 1);
    localparam logic [4:0] c_last_load = 5'(NREGS - 2);
    localparam logic [4:0] c_xzr       = 5'(XZR_IDX);
    localparam logic [4:0] c_one       = 5'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_D_RD  = 3'd1,
        S_D_OUT = 3'd2,
        S_LOAD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     idx_q, idx_d;
    logic [N-1:0]   out_data_q, out_data_d;
    logic [4:0]     out_idx_q, out_idx_d;
    logic           out_valid_q, out_valid_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        rf_ra       = 5'd0;
        rf_we       = 1'b0;
        rf_wa       = 5'd0;
        rf_wd       = '0;
        in_ready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                idx_d = 5'd0;
                if (start) begin
                    state_d = mode ? S_LOAD : S_D_RD;
                end
            end
            S_D_RD: begin
                rf_ra       = idx_q;
                // The zero register is reported as 0 whatever the file returns.
                out_data_d  = (idx_q == c_xzr) ? '0 : rf_rd;
                out_idx_d   = idx_q;
                out_valid_d = 1'b1;
                state_d     = S_D_OUT;
            end
            S_D_OUT: begin
                rf_ra = idx_q;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == c_last_dump) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + c_one;
                        state_d = S_D_RD;
                    end
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                rf_wa    = idx_q;
                rf_wd    = in_data;
                rf_we    = in_valid;
                if (in_valid) begin
                    if (idx_q == c_last_load) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + c_one;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 5'd0;
            out_data_q  <= '0;
            out_idx_q   <= 5'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;

    // A LOAD must never target the zero register.
    a_no_xzr_write: assert property (@(posedge clk) disable iff (reset)
        !(rf_we && rf_wa == c_xzr));

endmodule

`default_nettype wire
